// File: rtl/closest_hit_select_pkg.sv
// Shared types and constants for the closest-hit reduction stage.
//   fp32_t      : raw IEEE-754 single-precision bit pattern
//   cand_t      : selected root of one sphere test {vld, t}
//   hit_rec_t   : hit record {vld, t, id}
//   state_e     : ray accumulation FSM states
package closest_hit_select_pkg;

  localparam int unsigned ID_W                = 8;
  localparam int unsigned FP_W                = 32;
  localparam int unsigned CNT_W               = 16;
  localparam int unsigned LATENCY_CLOSEST_HIT = 2;

  typedef logic [FP_W-1:0] fp32_t;

  // Roots must be strictly greater than 0.001f.
  localparam fp32_t FP32_T_MIN = 32'h3A83126F;

  typedef struct packed {
    logic  vld;
    fp32_t t;
  } cand_t;

  typedef struct packed {
    logic            vld;
    fp32_t           t;
    logic [ID_W-1:0] id;
  } hit_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/closest_hit_select_if.sv
// Candidate stream in / hit record out bundle for closest_hit_select.
//   in_*       : one (t0, t1) root pair per tested sphere, framed by in_first/in_last
//   hit_*      : one-cycle result pulse per completed ray, held between pulses
//   tested_cnt : candidates accumulated for the reported ray (saturating)
//   err_seq    : sticky sequence-error flag
// master = intersection side (drives in_*), slave = this stage.
interface closest_hit_select_if;
  import closest_hit_select_pkg::*;

  logic                  in_vld;
  fp32_t                 in_t0;
  fp32_t                 in_t1;
  logic [ID_W-1:0]       in_id;
  logic                  in_first;
  logic                  in_last;
  logic                  hit_vld;
  logic                  hit;
  fp32_t                 hit_t;
  logic [ID_W-1:0]       hit_id;
  logic [CNT_W-1:0]      tested_cnt;
  logic                  err_seq;

  modport master (
    output in_vld, in_t0, in_t1, in_id, in_first, in_last,
    input  hit_vld, hit, hit_t, hit_id, tested_cnt, err_seq
  );

  modport slave (
    input  in_vld, in_t0, in_t1, in_id, in_first, in_last,
    output hit_vld, hit, hit_t, hit_id, tested_cnt, err_seq
  );

endinterface

// File: rtl/closest_hit_select_fp32_root_select.sv
// Combinational root picker: nearest usable root of one sphere.
//   t0_i, t1_i : near / far root bit patterns
//   bound_i    : magnitude bits of the lower bound (exclusive)
//   vld_o      : a usable root exists
//   t_o        : t0 if usable, else t1 if usable, else 0
module fp32_root_select
  import closest_hit_select_pkg::*;
(
  input  fp32_t       t0_i,
  input  fp32_t       t1_i,
  input  logic [30:0] bound_i,
  output logic        vld_o,
  output fp32_t       t_o
);

  logic use0_c;
  logic use1_c;

  // Positive, finite (NaN marks a miss), and beyond the bound. Raw-bit
  // compare is an exact float compare since both operands are positive.
  assign use0_c = ~t0_i[31] && (t0_i[30:23] != 8'hFF) && (t0_i[30:0] > bound_i);
  assign use1_c = ~t1_i[31] && (t1_i[30:23] != 8'hFF) && (t1_i[30:0] > bound_i);

  assign vld_o = use0_c | use1_c;
  assign t_o   = use0_c ? t0_i : (use1_c ? t1_i : '0);

endmodule

// File: rtl/closest_hit_select.sv
// Per-ray nearest-hit reduction. Stage 1 registers the candidate and picks
// its root; stage 2 merges it into the accumulator and registers the result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : candidate stream in, hit record out (slave modport)
module closest_hit_select
  import closest_hit_select_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  closest_hit_select_if.slave  bus
);

  // Stage 1 registers
  logic            s1_vld_q;
  logic            s1_first_q;
  logic            s1_last_q;
  logic [ID_W-1:0] s1_id_q;
  fp32_t           s1_t0_q;
  fp32_t           s1_t1_q;

  // Stage 2 state
  state_e           state_q,  state_d;
  hit_rec_t         best_q,   best_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             err_q,    err_d;
  logic             hit_vld_q, hit_vld_d;
  hit_rec_t         out_q,    out_d;
  logic [CNT_W-1:0] tested_q, tested_d;

  logic             cand_vld;
  fp32_t            cand_t;
  hit_rec_t         cand;
  hit_rec_t         merged;
  logic [CNT_W-1:0] merged_cnt;
  logic             beat_used;
  logic             take;

  fp32_root_select u_root_select (
    .t0_i    (s1_t0_q),
    .t1_i    (s1_t1_q),
    .bound_i (FP32_T_MIN[30:0]),
    .vld_o   (cand_vld),
    .t_o     (cand_t)
  );

  assign cand = '{vld: cand_vld, t: cand_t, id: s1_id_q};

  // Next-state: frame checking, accumulate, emit on the last beat
  always_comb begin
    state_d    = state_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    hit_vld_d  = 1'b0;
    out_d      = out_q;
    tested_d   = tested_q;
    merged     = '0;
    merged_cnt = '0;
    beat_used  = 1'b0;
    take       = 1'b0;

    if (s1_vld_q) begin
      if (s1_first_q) begin
        // A first beat always (re)starts a ray; one arriving mid-ray drops it.
        if (state_q == ST_ACC) err_d = 1'b1;
        merged     = cand;
        merged_cnt = CNT_W'(1);
        beat_used  = 1'b1;
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        // Strict less-than keeps the earlier sphere on ties.
        take       = cand.vld && (!best_q.vld || (cand.t[30:0] < best_q.t[30:0]));
        merged     = take ? cand : best_q;
        merged_cnt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        beat_used  = 1'b1;
      end

      if (beat_used) begin
        if (s1_last_q) begin
          hit_vld_d = 1'b1;
          out_d.vld = merged.vld;
          out_d.t   = merged.vld ? merged.t  : '0;
          out_d.id  = merged.vld ? merged.id : '0;
          tested_d  = merged_cnt;
          state_d   = ST_IDLE;
        end else begin
          best_d  = merged;
          cnt_d   = merged_cnt;
          state_d = ST_ACC;
        end
      end
    end
  end

  // Stage 1 capture; payload only loads on valid beats
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_id_q    <= '0;
      s1_t0_q    <= '0;
      s1_t1_q    <= '0;
    end else begin
      s1_vld_q <= bus.in_vld;
      if (bus.in_vld) begin
        s1_first_q <= bus.in_first;
        s1_last_q  <= bus.in_last;
        s1_id_q    <= bus.in_id;
        s1_t0_q    <= bus.in_t0;
        s1_t1_q    <= bus.in_t1;
      end
    end
  end

  // Stage 2 state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      best_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      hit_vld_q <= 1'b0;
      out_q     <= '0;
      tested_q  <= '0;
    end else begin
      state_q   <= state_d;
      best_q    <= best_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      hit_vld_q <= hit_vld_d;
      out_q     <= out_d;
      tested_q  <= tested_d;
    end
  end

  assign bus.hit_vld    = hit_vld_q;
  assign bus.hit        = out_q.vld;
  assign bus.hit_t      = out_q.t;
  assign bus.hit_id     = out_q.id;
  assign bus.tested_cnt = tested_q;
  assign bus.err_seq    = err_q;

endmodule

// File: doc/closest_hit_select.md
# closest_hit_select

Streaming reduction stage directly downstream of the ray/sphere intersection pipeline. Per ray, it consumes one (t0, t1) pair per tested sphere, drops invalid or behind-origin roots, and tracks the nearest valid hit. On the ray's last sphere it emits a single hit record (hit flag, t, sphere id) to the shading stage. It is fully pipelined, accepts one candidate per clock, and applies no backpressure, because the intersection pipeline cannot stall.

## Interface
- ID_W, 8, sphere id width
- T_MIN, 32'h3A83126F (0.001f), fp32 lower bound; roots must be strictly greater than this
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_vld  in  1  candidate valid; driven from the intersection core's result_vld
- in_t0  in  32 (fp32_t)  near root, b - sqrt(disc)
- in_t1  in  32 (fp32_t)  far root, b + sqrt(disc)
- in_id  in  ID_W  sphere id; the caller delays it to align with in_vld
- in_first  in  1  first sphere of the ray
- in_last  in  1  last sphere of the ray
- hit_vld  out  1  one-cycle pulse carrying the result for one ray
- hit  out  1  ray hit at least one sphere
- hit_t  out  32  nearest t; 0 when hit=0
- hit_id  out  ID_W  id of the nearest sphere; 0 when hit=0
- tested_cnt  out  16  candidates accumulated for the reported ray, saturating at 16'hFFFF
- err_seq  out  1  sticky sequence-error flag; cleared only by rst

## Operation
- Root classification:
  - A root is usable iff its sign bit is 0, its exponent is not 8'hFF (rejects NaN and Inf), and its bits are greater than T_MIN's bits.
  - A NaN arises from sqrt of a negative discriminant and means the ray missed that sphere.
  - All comparisons are unsigned 31-bit magnitude compares on the raw bits. This is valid because every compared value is positive.
- Candidate selection: use t0 if usable; otherwise t1 if usable (ray origin inside the sphere); otherwise the candidate is a miss.
- Accumulator: best_vld, best_t, best_id, cnt, and an open flag.
  - On in_first, the accumulator is reloaded from the current candidate and cnt=1. No comparison is made.
  - On a non-first candidate, the accumulator is replaced iff the candidate is valid and (best_vld=0 or cand_t < best_t).
  - Ties keep the earlier sphere (strict less-than).
- FSM with two states:
  - IDLE → ACC on in_first && !in_last.
  - ACC → IDLE on in_last.
  - in_first && in_last is a single-sphere ray; the FSM stays in IDLE and still emits a result.
- Sequence errors set err_seq:
  - in_vld && !in_first while in IDLE: the beat is discarded.
  - in_first while in ACC: the open ray is discarded without output, and accumulation restarts on the new beat.
- Output: on in_last, the merged result (accumulator plus this beat) is presented on hit_*. hit_t and hit_id are forced to 0 when the ray has no valid hit.
- Inputs are ignored whenever in_vld=0; the accumulator holds its value.

## Timing
- Stage 1 registers the inputs and classifies and selects the candidate.
- Stage 2 compares against and updates the accumulator, and registers the output.
- Latency: in_vld && in_last at cycle N gives hit_vld=1 at N+2. Define LATENCY_CLOSEST_HIT = 2.
- Throughput is one candidate per clock. Back-to-back rays are supported: a last beat at N followed by a first beat at N+1 is legal, and both results are emitted, at N+2 and N+3.
- hit_vld is high for exactly one cycle per completed ray. Between pulses, hit, hit_t, hit_id and tested_cnt hold their last value.
- Reset values: hit_vld=0, hit=0, hit_t=0, hit_id=0, tested_cnt=0, err_seq=0, FSM=IDLE, accumulator cleared, pipeline valids cleared.
- If rst is asserted mid-ray, the partial ray is dropped, no pulse is produced, and any beat in flight is squashed.

## Structure
- defines.svh gains:
  - hit_t struct {logic vld; fp32_t t; logic [ID_W-1:0] id;}
  - FP32_T_MIN constant
  - the LATENCY_CLOSEST_HIT macro
- Sub-module fp32_root_select (combinational, instantiated in stage 1): takes t0, t1 and the bound, and returns {vld, t}.
- The magnitude compare in stage 2 is inline.

## Test plan
- Single-sphere ray, first=last, t0=0x3F800000 (1.0), t1=0x40000000 (2.0), id=3 → at N+2: hit=1, hit_t=0x3F800000, hit_id=3, tested_cnt=1.
- Three spheres: ids 0/1/2 with t0 = 3.0 (0x40400000), 0.5 (0x3F000000), NaN (0x7FC00000) → hit_t=0x3F000000, hit_id=1, tested_cnt=3.
- Origin inside the sphere: t0=0xBF800000 (-1.0), t1=0x40000000 (2.0) → hit_t=0x40000000. Also t0=0x3A000000 (below T_MIN), t1=NaN → hit=0, hit_t=0, hit_id=0.
- Tie plus back-to-back rays: ray A has ids 5 and 6, both t0=1.0, with last at cycle N; ray B starts at N+1 and has all NaN. Required: A gives hit_id=5 at N+2; B gives hit=0 at N+3; no gaps in the stream.
- Sequence errors: a non-first beat in IDLE, then in_first while in ACC → err_seq=1 and stays set; only the restarted ray is reported; err_seq clears only on rst.
- Reset mid-ray: assert rst one cycle after in_first → no hit_vld; all outputs are 0 in the cycle after rst. A ray started after rst is reported correctly.
